// File: rtl/openfire_mem_arbiter.sv
// openfire_mem_arbiter: shares one single-port 32-bit memory between the
// openfire_cpu fetch port (imem) and data port (dmem). Each access runs
// IDLE -> {D_ACC | I_ACC} -> DONE, with big-endian lane formatting, a
// starvation guard that forces a fetch after D_MAX back-to-back data grants,
// and a timeout that ends a stalled access with an error completion.
module openfire_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int D_MAX   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_re,
  output logic [31:0]       imem_data_out,
  output logic              imem_done,
  output logic              imem_err,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmem_re,
  input  logic              dmem_we,
  input  logic [1:0]        dmem_input_sel,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_done,
  output logic              dmem_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_D_ACC, S_I_ACC, S_DONE} state_e;

  localparam logic [1:0]  SZ_WORD  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_BYTE  = 2'b10;
  localparam logic [7:0]  D_MAX_C  = 8'(D_MAX);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              is_d_q, is_d_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [7:0]        starve_q, starve_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [31:0]       imem_data_q, imem_data_d;
  logic [31:0]       dmem_rdata_q, dmem_rdata_d;

  logic              dmem_req, grant_d, grant_i, in_acc;
  logic [1:0]        sel_norm;
  logic [31:0]       rd_fmt;

  assign dmem_req = dmem_re | dmem_we;
  assign sel_norm = (dmem_input_sel == 2'b11) ? SZ_WORD : dmem_input_sel;
  // The data port wins contention unless imem has waited D_MAX grants.
  assign grant_d  = dmem_req && !(imem_re && (D_MAX != 0) && (starve_q == D_MAX_C));
  assign grant_i  = imem_re && !grant_d;
  assign in_acc   = (state_q == S_D_ACC) || (state_q == S_I_ACC);

  // Select the addressed lane of the returned word and right-justify it.
  always_comb begin
    rd_fmt = mem_rdata;
    case (size_q)
      SZ_HALF: rd_fmt = off_q[1] ? {16'h0, mem_rdata[15:0]} : {16'h0, mem_rdata[31:16]};
      SZ_BYTE: begin
        case (off_q)
          2'd0:    rd_fmt = {24'h0, mem_rdata[31:24]};
          2'd1:    rd_fmt = {24'h0, mem_rdata[23:16]};
          2'd2:    rd_fmt = {24'h0, mem_rdata[15:8]};
          default: rd_fmt = {24'h0, mem_rdata[7:0]};
        endcase
      end
      default: rd_fmt = mem_rdata;
    endcase
  end

  // Next-state logic: arbitration, access latching, completion and timeout.
  always_comb begin
    // NOTE: every *_d starts from its held value so no path leaves a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    is_d_d       = is_d_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    imem_data_d  = imem_data_q;
    dmem_rdata_d = dmem_rdata_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        tmo_d = '0;
        if (grant_d) begin
          state_d  = S_D_ACC;
          is_d_d   = 1'b1;
          addr_d   = {dmem_addr[ADDR_W-1:2], 2'b00};
          off_d    = dmem_addr[1:0];
          size_d   = sel_norm;
          // A simultaneous load and store is serviced as a load.
          we_d     = dmem_we && !dmem_re;
          be_d     = 4'b1111;
          wdata_d  = dmem_wdata;
          if (dmem_we && !dmem_re) begin
            case (sel_norm)
              SZ_HALF: begin
                be_d    = dmem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{dmem_wdata[15:0]}};
              end
              SZ_BYTE: begin
                be_d    = 4'b1000 >> dmem_addr[1:0];
                wdata_d = {4{dmem_wdata[7:0]}};
              end
              default: ;
            endcase
          end
          if (!imem_re)                starve_d = '0;
          else if (starve_q != D_MAX_C) starve_d = starve_q + 8'd1;
        end else if (grant_i) begin
          state_d  = S_I_ACC;
          is_d_d   = 1'b0;
          addr_d   = {imem_addr[ADDR_W-1:2], 2'b00};
          off_d    = imem_addr[1:0];
          size_d   = SZ_WORD;
          we_d     = 1'b0;
          be_d     = 4'b1111;
          starve_d = '0;
        end
      end
      S_D_ACC, S_I_ACC: begin
        if (mem_ready) begin
          state_d = S_DONE;
          if (!is_d_q)    imem_data_d  = mem_rdata;
          else if (!we_q) dmem_rdata_d = rd_fmt;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!is_d_q)    imem_data_d  = '0;
          else if (!we_q) dmem_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      is_d_q       <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      starve_q     <= '0;
      tmo_q        <= '0;
      imem_data_q  <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      size_q       <= size_d;
      we_q         <= we_d;
      is_d_q       <= is_d_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      imem_data_q  <= imem_data_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  assign mem_re        = in_acc && !we_q;
  assign mem_we        = in_acc && we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign imem_done     = (state_q == S_DONE) && !is_d_q;
  assign dmem_done     = (state_q == S_DONE) && is_d_q;
  assign imem_err      = imem_done && err_q;
  assign dmem_err      = dmem_done && err_q;
  assign imem_data_out = imem_data_q;
  assign dmem_rdata    = dmem_rdata_q;

endmodule

// File: tb/tb_openfire_mem_arbiter.sv
// Scoreboard bench for openfire_mem_arbiter: stimulus pushes the expected
// completion, a negedge monitor pops and compares on every done pulse.
module tb_openfire_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data_out;
  logic        imem_re, imem_done, imem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_re, dmem_we, dmem_done, dmem_err;
  logic [1:0]  dmem_input_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_re, mem_we, mem_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        re;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[9];

  openfire_mem_arbiter #(.ADDR_W(32), .D_MAX(2), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_data_out(imem_data_out),
    .imem_done(imem_done), .imem_err(imem_err),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .dmem_input_sel(dmem_input_sel), .dmem_rdata(dmem_rdata),
    .dmem_done(dmem_done), .dmem_err(dmem_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (imem_done || dmem_done) begin
      if (imem_done && dmem_done) begin
        check("both_done", 32'(imem_done & dmem_done), 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", {30'd0, imem_done, dmem_done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_port", 32'(dmem_done), 32'(e.is_d));
        if (e.is_d) begin
          check("dmem_err", 32'(dmem_err), 32'(e.err));
          if (e.chk_data) check("dmem_rdata", dmem_rdata, e.data);
        end else begin
          check("imem_err", 32'(imem_err), 32'(e.err));
          if (e.chk_data) check("imem_data_out", imem_data_out, e.data);
        end
      end
    end
  end

  // Wait (bounded) for the negedge at which any done pulse is visible.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (imem_done || dmem_done) seen = 1'b1;
    end
    if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clock);
    dmem_addr = v.addr; dmem_wdata = v.wdata; dmem_input_sel = v.sel;
    dmem_re = v.re; dmem_we = v.we; mem_rdata = v.rdata;
    e.is_d = 1'b1; e.chk_data = v.re; e.data = v.exp_rd; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clock);
    check("vec_mem_re", 32'(mem_re), 32'(v.re));
    check("vec_mem_we", 32'(mem_we), 32'(!v.re));
    check("vec_mem_addr", mem_addr, {v.addr[31:2], 2'b00});
    check("vec_mem_be", 32'(mem_be), 32'(v.be));
    if (!v.re) check("vec_mem_wdata", mem_wdata, v.mwdata);
    wait_done("vec");
    dmem_re = 1'b0; dmem_we = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   cnt;
    //             re    we    sel    addr   wdata         rdata         be       mwdata        exp_rd
    vecs[0] = '{1'b0, 1'b1, 2'b10, 32'h21, 32'h000000A5, 32'h0,        4'b0100, 32'hA5A5A5A5, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 32'h22, 32'h0,        32'h1234ABCD, 4'b1111, 32'h0,        32'h0000ABCD};
    vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h20, 32'h0,        32'h1234ABCD, 4'b1111, 32'h0,        32'h00000012};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h23, 32'h0,        32'h1234ABCD, 4'b1111, 32'h0,        32'h000000CD};
    vecs[4] = '{1'b0, 1'b1, 2'b01, 32'h21, 32'hFFFF5678, 32'h0,        4'b1100, 32'h56785678, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 32'h23, 32'h00009ABC, 32'h0,        4'b0011, 32'h9ABC9ABC, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 32'h44, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 2'b11, 32'h47, 32'h0,        32'h89ABCDEF, 4'b1111, 32'h0,        32'h89ABCDEF};
    vecs[8] = '{1'b1, 1'b1, 2'b10, 32'h31, 32'h00000077, 32'h00FF0000, 4'b1111, 32'h0,        32'h000000FF};

    reset = 1'b0; imem_addr = '0; imem_re = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_re = 1'b0; dmem_we = 1'b0;
    dmem_input_sel = 2'b00; mem_rdata = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_imem_data", imem_data_out, 32'd0);
    check("rst_dmem_rdata", dmem_rdata, 32'd0);
    reset = 1'b1;

    // Fetch with memory ready immediately.
    @(negedge clock);
    imem_addr = 32'h10; imem_re = 1'b1; mem_rdata = 32'hDEADBEEF;
    e = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0}; exp_q.push_back(e);
    @(negedge clock);
    check("fetch_mem_re", 32'(mem_re), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h10);
    check("fetch_mem_be", 32'(mem_be), 32'hF);
    check("fetch_not_done_yet", 32'(imem_done), 32'd0);
    wait_done("fetch");
    imem_re = 1'b0;

    // Directed data-port vectors.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: both held, D_MAX=2 gives D, D, I, D, D, I.
    @(negedge clock);
    imem_addr = 32'h100; dmem_addr = 32'h200; dmem_input_sel = 2'b00;
    mem_rdata = 32'h55AA00FF;
    for (int k = 0; k < 6; k++) begin
      e = '{(k % 3) != 2, 1'b1, 32'h55AA00FF, 1'b0};
      exp_q.push_back(e);
    end
    imem_re = 1'b1; dmem_re = 1'b1;
    for (int k = 0; k < 6; k++) wait_done("contend");
    imem_re = 1'b0; dmem_re = 1'b0;

    // Timeout: memory never ready on a data read.
    @(negedge clock);
    mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
    dmem_addr = 32'h50; dmem_input_sel = 2'b00; dmem_re = 1'b1;
    e = '{1'b1, 1'b1, 32'h0, 1'b1}; exp_q.push_back(e);
    cnt = 0;
    for (int i = 0; i < 40 && !dmem_done; i++) begin
      @(negedge clock);
      if (mem_re) cnt++;
    end
    check("tmo_acc_cycles", 32'(cnt), 32'd8);
    check("tmo_done_seen", 32'(dmem_done), 32'd1);
    dmem_re = 1'b0;

    // Reset in the middle of a fetch drops it without a done.
    @(negedge clock);
    imem_addr = 32'h60; imem_re = 1'b1;
    @(negedge clock);
    check("rmid_mem_re_before", 32'(mem_re), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rmid_mem_re_after", 32'(mem_re), 32'd0);
    check("rmid_no_done", 32'(imem_done), 32'd0);
    check("rmid_dmem_rdata", dmem_rdata, 32'd0);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    e = '{1'b0, 1'b1, 32'h0BADF00D, 1'b0}; exp_q.push_back(e);
    @(negedge clock);
    check("reissue_mem_re", 32'(mem_re), 32'd1);
    check("reissue_mem_addr", mem_addr, 32'h60);
    wait_done("reissue");
    imem_re = 1'b0;

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
